// File: rtl/starship_rom_reader.sv
// Burst read initiator for the StarshipROM macro: one read per cycle, credit-limited
// by a 4-entry response buffer so the ROM never runs ahead of the consumer.
`timescale 1ns/1ps
module starship_rom_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  output logic                  busy,
  output logic                  rom_me,
  output logic                  rom_oe,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam int DEPTH = 4;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, rom_addr_q;
  logic [LEN_WIDTH-1:0]  len_q, issued_q, returned_q;
  logic                  b_valid_q, b_last_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      last_q;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;
  logic                  req_ready_q, busy_q, rom_oe_q;

  logic req_fire, issue, push, pop;

  // A word in flight on rom_q already owns a slot; no credit for a same-cycle pop.
  assign issue    = (state_q == BURST) && ((count_q + 3'(b_valid_q)) < 3'(DEPTH));
  assign push     = b_valid_q;
  assign pop      = (count_q != 3'd0) && resp_ready;
  assign req_fire = req_valid && req_ready_q;

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign rom_oe      = rom_oe_q;
  assign rom_me      = issue;
  assign rom_address = issue ? addr_q : rom_addr_q;
  assign resp_valid  = (count_q != 3'd0);
  assign resp_data   = mem_q[rd_ptr_q];
  assign resp_last   = resp_valid && last_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire) state_d = BURST;
      BURST:   if (issue && (issued_q == len_q)) state_d = DRAIN;
      DRAIN:   if (pop && (returned_q == len_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rom_oe_q    <= 1'b0;
      addr_q      <= '0;
      rom_addr_q  <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      b_valid_q   <= 1'b0;
      b_last_q    <= 1'b0;
      last_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      rom_oe_q    <= (state_d != IDLE);

      if (req_fire) begin
        addr_q     <= req_addr;
        len_q      <= req_len;
        issued_q   <= '0;
        returned_q <= '0;
      end

      // Address wraps naturally at 2^ADDR_WIDTH.
      if (issue) begin
        rom_addr_q <= addr_q;
        addr_q     <= addr_q + ADDR_WIDTH'(1);
        issued_q   <= issued_q + LEN_WIDTH'(1);
        b_last_q   <= (issued_q == len_q);
      end
      b_valid_q <= issue;

      if (push) begin
        mem_q[wr_ptr_q]  <= rom_q;
        last_q[wr_ptr_q] <= b_last_q;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end

      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 2'd1;
        returned_q <= returned_q + LEN_WIDTH'(1);
      end

      count_q <= count_q + 3'(push) - 3'(pop);
    end
  end

endmodule

// File: doc/starship_rom_reader.md
# starship_rom_reader

Burst read initiator for the StarshipROM macro interface (clock, me, oe, 11-bit address, 32-bit registered q). It accepts a start address and beat count on a valid/ready request port and issues one ROM read per cycle. It captures the one-cycle-latency `q` into a 4-entry buffer and returns the words on a valid/ready response stream with a last flag. It sits between the boot/debug fetch path and the mask ROM, so the ROM is never read faster than the consumer drains data.

## Interface
- `ADDR_WIDTH`, 11: ROM word address width; the ROM depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: ROM word width.
- `LEN_WIDTH`, 8: width of the burst length field, which is encoded as beats-1.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: burst request valid.
- `req_ready` out 1: high only in IDLE.
- `req_addr` in ADDR_WIDTH: first word address.
- `req_len` in LEN_WIDTH: number of beats minus 1.
- `resp_valid` out 1: response word valid.
- `resp_ready` in 1: consumer accepts the response word.
- `resp_data` out DATA_WIDTH: ROM word.
- `resp_last` out 1: marks the final beat of the burst.
- `busy` out 1: high whenever state is not IDLE.
- `rom_me` out 1: ROM read enable.
- `rom_oe` out 1: ROM output enable.
- `rom_address` out ADDR_WIDTH: ROM address.
- `rom_q` in DATA_WIDTH: ROM data; valid in the cycle after an `rom_me` cycle while `rom_oe` is high.

## Operation
- States are IDLE, BURST and DRAIN.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid && req_ready`: latch `addr_r`=`req_addr`, `len_r`=`req_len`, `issued`=0, `returned`=0; go to BURST.
- **BURST:**
  - Issue condition: `fifo_count + b_valid < 4`.
  - When the issue condition holds: `rom_me`=1, `rom_address`=`addr_r`, `addr_r` += 1, `issued` += 1.
  - Address increment wraps modulo 2^ADDR_WIDTH. Address 2047 is followed by address 0; no error is raised.
  - When the issue with `issued == len_r` occurs, go to DRAIN in the next cycle.
- **DRAIN:**
  - No further issues.
  - Return to IDLE on the response handshake whose `returned == len_r`.
- `b_valid` register: set in the cycle after an `rom_me` cycle. While `b_valid`=1, `rom_q` is pushed into the FIFO at the clock edge.
- `rom_oe`=1 in BURST and DRAIN and 0 in IDLE. `rom_q` is never sampled while `rom_oe`=0, because the bus is Z.
- FIFO:
  - 4 entries, registered output.
  - `resp_valid` = FIFO not empty; `resp_data` = head entry.
  - Each entry carries a last flag, set when the pushed beat index equals `len_r`.
  - Push and pop in the same cycle are allowed, including when the FIFO is full or empty.
  - The issue condition counts no credit for a same-cycle pop, so overflow is impossible by construction.
- `returned` increments on every `resp_valid && resp_ready`.
- A burst is `len_r`+1 beats; `req_len`=255 gives 256 beats.
- `LEN_WIDTH`-bit counters compare for equality only and never overflow within a burst.
- A new request is not accepted until the last beat of the current burst has been handshaken.

## Timing
- **Reset values** (asynchronous assertion, all outputs forced immediately):
  - `req_ready`=0 while `reset_n`=0, and 1 from the first cycle after deassertion.
  - `resp_valid`=0, `resp_last`=0, `resp_data`=0, `busy`=0.
  - `rom_me`=0, `rom_oe`=0, `rom_address`=0.
  - FIFO empty, `b_valid`=0, state IDLE.
- **Reset mid-burst:** in-flight ROM data and FIFO contents are discarded with no response, and the next request after release starts clean.
- **Latency:**
  - Request handshake at edge E0.
  - `rom_me` high in cycle 1.
  - `rom_q` is valid in cycle 2 and is pushed at E2.
  - `resp_valid` is high in cycle 3.
- **Throughput:** with `resp_ready` held high, one beat per cycle. In steady state `fifo_count`=1 and `b_valid`=1, so the issue condition holds every cycle.
- **Backpressure:**
  - When `resp_ready` is low, issuing stalls once `fifo_count + b_valid` reaches 4.
  - Up to 4 words are buffered; no word is lost or duplicated.
  - Issuing resumes in the cycle after the FIFO count drops.
- `rom_address` holds its last value when `rom_me`=0.
- **Single-beat burst (`req_len`=0):** BURST lasts 1 cycle, then DRAIN. IDLE is reached in the cycle after the response handshake, and `req_ready`=1 in that cycle.
- **Response stability:** `resp_valid`, `resp_data` and `resp_last` must hold steady while `resp_valid && !resp_ready`.

## Test plan
- **Reset:** hold `reset_n`=0, then release with no request. Expect all outputs at their reset values, and `req_ready`=1 from the first cycle after release.
- **Full-speed burst:** preload `rom[i]`=0xA5000000+i; request addr 0x010, len 7, `resp_ready`=1.
  - 8 words 0xA5000010..0xA5000017 arrive on consecutive cycles.
  - The first word arrives 3 cycles after the handshake.
  - `resp_last` only on 0xA5000017.
  - `busy` drops the cycle after the last handshake.
- **Wrap-around:** request addr 0x7FE, len 3. Expect words from addresses 0x7FE, 0x7FF, 0x000, 0x001, in that order.
- **Backpressure:** request len 15 with `resp_ready` low for 10 cycles, then random toggling.
  - `rom_me` stops after at most 4 outstanding words.
  - All 16 words arrive in order with no duplicates.
  - `resp_data` is stable whenever `resp_ready` is low.
- **Single-beat bursts back to back:** len 0 requests at 0x100 and then 0x200. Expect the second request accepted only after the first beat's handshake, and each beat flagged `resp_last`.
- **Reset mid-operation:** assert `reset_n` low during beat 3 of a 16-beat burst.
  - `rom_me`, `rom_oe` and `resp_valid` go low immediately.
  - A following request for addr 0x020, len 1 returns exactly rom[0x20] and rom[0x21].
